// File: rtl/tl_ram_front_end.sv
// tl_ram_front_end: A-request FIFO with range check, local denied responses and in-order D merge.
// Optional request/error statistics are built when TL_RAM_FE_STATS_EN is defined.
module tl_ram_front_end #(
   parameter int          DEPTH      = 2,
   parameter logic [32:0] BASE_ADDR  = 33'h080000000,
   parameter logic [32:0] SIZE_BYTES = 33'h080000000
) (
   input  logic        clock,
   input  logic        reset,
   output logic        auto_in_a_ready,
   input  logic        auto_in_a_valid,
   input  logic [2:0]  auto_in_a_bits_opcode,
   input  logic [2:0]  auto_in_a_bits_param,
   input  logic [1:0]  auto_in_a_bits_size,
   input  logic [9:0]  auto_in_a_bits_source,
   input  logic [32:0] auto_in_a_bits_address,
   input  logic [7:0]  auto_in_a_bits_mask,
   input  logic [63:0] auto_in_a_bits_data,
   input  logic        auto_in_a_bits_corrupt,
   input  logic        auto_in_d_ready,
   output logic        auto_in_d_valid,
   output logic [2:0]  auto_in_d_bits_opcode,
   output logic [1:0]  auto_in_d_bits_size,
   output logic [9:0]  auto_in_d_bits_source,
   output logic        auto_in_d_bits_denied,
   output logic [63:0] auto_in_d_bits_data,
   input  logic        auto_out_a_ready,
   output logic        auto_out_a_valid,
   output logic [2:0]  auto_out_a_bits_opcode,
   output logic [2:0]  auto_out_a_bits_param,
   output logic [1:0]  auto_out_a_bits_size,
   output logic [9:0]  auto_out_a_bits_source,
   output logic [32:0] auto_out_a_bits_address,
   output logic [7:0]  auto_out_a_bits_mask,
   output logic [63:0] auto_out_a_bits_data,
   output logic        auto_out_a_bits_corrupt,
   output logic        auto_out_d_ready,
   input  logic        auto_out_d_valid,
   input  logic [2:0]  auto_out_d_bits_opcode,
   input  logic [1:0]  auto_out_d_bits_size,
   input  logic [9:0]  auto_out_d_bits_source,
   input  logic [63:0] auto_out_d_bits_data,
   output logic [31:0] stat_reads,
   output logic [31:0] stat_writes,
   output logic [31:0] stat_errors
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [33:0] LIMIT = {1'b0, BASE_ADDR} + {1'b0, SIZE_BYTES};
   typedef struct packed {
      logic [2:0]  opcode;
      logic [2:0]  param;
      logic [1:0]  size;
      logic [9:0]  source;
      logic [32:0] address;
      logic [7:0]  mask;
      logic [63:0] data;
      logic        corrupt;
   } req_t;
   req_t        mem [DEPTH];
   req_t        head;
   logic [AW:0] wr_ptr, rd_ptr;
   logic [1:0]  outstanding;
   logic        err_valid, err_opcode;
   logic [1:0]  err_size;
   logic [9:0]  err_source;
   logic        full, head_valid, legal, enq, out_fire, d_fire, err_load, deq;
   assign head       = mem[rd_ptr[AW-1:0]];
   assign head_valid = wr_ptr != rd_ptr;
   assign full       = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
   assign legal      = (head.opcode inside {3'd0, 3'd1, 3'd4}) && head.address >= BASE_ADDR
                       && {1'b0, head.address} < LIMIT;
   assign enq        = auto_in_a_valid & ~full;
   assign out_fire   = auto_out_a_valid & auto_out_a_ready;
   assign d_fire     = auto_out_d_valid & auto_out_d_ready;
   // An illegal head is only answered once every earlier RAM response has drained.
   assign err_load   = head_valid & ~legal & ~err_valid & (outstanding == 2'd0);
   assign deq        = out_fire | err_load;
   assign auto_in_a_ready         = ~full;
   assign auto_out_a_valid        = head_valid & legal & ~err_valid;
   assign auto_out_a_bits_opcode  = head.opcode;
   assign auto_out_a_bits_param   = head.param;
   assign auto_out_a_bits_size    = head.size;
   assign auto_out_a_bits_source  = head.source;
   assign auto_out_a_bits_address = head.address;
   assign auto_out_a_bits_mask    = head.mask;
   assign auto_out_a_bits_data    = head.data;
   assign auto_out_a_bits_corrupt = head.corrupt;
   assign auto_out_d_ready        = auto_in_d_ready & ~err_valid;
   assign auto_in_d_valid         = auto_out_d_valid | err_valid;
   assign auto_in_d_bits_opcode   = err_valid ? {2'b0, err_opcode} : auto_out_d_bits_opcode;
   assign auto_in_d_bits_size     = err_valid ? err_size : auto_out_d_bits_size;
   assign auto_in_d_bits_source   = err_valid ? err_source : auto_out_d_bits_source;
   assign auto_in_d_bits_denied   = err_valid;
   assign auto_in_d_bits_data     = err_valid ? 64'd0 : auto_out_d_bits_data;
   // FIFO storage needs no reset; only the pointers define occupancy.
   always_ff @(posedge clock)
      if (enq) mem[wr_ptr[AW-1:0]] <= '{auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size,
                                        auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
                                        auto_in_a_bits_data, auto_in_a_bits_corrupt};
   // FIFO pointers and the count of requests in flight at the RAM.
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         outstanding <= '0;
      end else begin
         wr_ptr      <= wr_ptr + {{AW{1'b0}}, enq};
         rd_ptr      <= rd_ptr + {{AW{1'b0}}, deq};
         outstanding <= outstanding + {1'b0, out_fire} - {1'b0, d_fire};
      end
   // Local denied response, held until the upstream D channel takes it.
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         err_valid  <= 1'b0;
         err_opcode <= 1'b0;
         err_size   <= '0;
         err_source <= '0;
      end else if (err_load) begin
         err_valid  <= 1'b1;
         err_opcode <= head.opcode inside {3'd2, 3'd3, 3'd4};
         err_size   <= head.size;
         err_source <= head.source;
      end else if (auto_in_d_ready) begin
         err_valid  <= 1'b0;
      end
`ifdef TL_RAM_FE_STATS_EN
   // Wrapping counters of dispatched reads, dispatched writes and locally denied requests.
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         stat_reads  <= '0;
         stat_writes <= '0;
         stat_errors <= '0;
      end else begin
         stat_reads  <= stat_reads + {31'd0, out_fire & (head.opcode == 3'd4)};
         stat_writes <= stat_writes + {31'd0, out_fire & (head.opcode != 3'd4)};
         stat_errors <= stat_errors + {31'd0, err_load};
      end
`else
   assign stat_reads  = '0;
   assign stat_writes = '0;
   assign stat_errors = '0;
`endif
endmodule

// File: tb/tb_tl_ram_front_end.sv
// tb_tl_ram_front_end: directed test of tl_ram_front_end against a one-slot RAM model.
module tb_tl_ram_front_end;
`ifdef TL_RAM_FE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   logic        clock = 1'b0, reset = 1'b1;
   logic        a_ready, a_valid = 1'b0;
   logic [2:0]  a_op = '0, a_param = '0;
   logic [1:0]  a_size = 2'd3;
   logic [9:0]  a_src = '0;
   logic [32:0] a_addr = '0;
   logic [7:0]  a_mask = 8'hFF;
   logic [63:0] a_data = '0;
   logic        a_corrupt = 1'b0;
   logic        d_ready = 1'b0, d_valid, d_denied;
   logic [2:0]  d_op;
   logic [1:0]  d_size;
   logic [9:0]  d_src;
   logic [63:0] d_data;
   logic        oa_ready, oa_valid, oa_corrupt;
   logic [2:0]  oa_op, oa_param;
   logic [1:0]  oa_size;
   logic [9:0]  oa_src;
   logic [32:0] oa_addr;
   logic [7:0]  oa_mask;
   logic [63:0] oa_data;
   logic        od_ready;
   logic [31:0] stat_reads, stat_writes, stat_errors;
   logic        ram_ready = 1'b1, rsp_v;
   logic [2:0]  rsp_op;
   logic [1:0]  rsp_size;
   logic [9:0]  rsp_src;
   logic [63:0] rsp_data;
   logic [63:0] ram [16];
   int          out_a_cnt = 0;
   int          n_checks = 0, n_fail = 0;

   tl_ram_front_end dut (
      .clock(clock), .reset(reset),
      .auto_in_a_ready(a_ready), .auto_in_a_valid(a_valid), .auto_in_a_bits_opcode(a_op),
      .auto_in_a_bits_param(a_param), .auto_in_a_bits_size(a_size), .auto_in_a_bits_source(a_src),
      .auto_in_a_bits_address(a_addr), .auto_in_a_bits_mask(a_mask), .auto_in_a_bits_data(a_data),
      .auto_in_a_bits_corrupt(a_corrupt),
      .auto_in_d_ready(d_ready), .auto_in_d_valid(d_valid), .auto_in_d_bits_opcode(d_op),
      .auto_in_d_bits_size(d_size), .auto_in_d_bits_source(d_src), .auto_in_d_bits_denied(d_denied),
      .auto_in_d_bits_data(d_data),
      .auto_out_a_ready(oa_ready), .auto_out_a_valid(oa_valid), .auto_out_a_bits_opcode(oa_op),
      .auto_out_a_bits_param(oa_param), .auto_out_a_bits_size(oa_size), .auto_out_a_bits_source(oa_src),
      .auto_out_a_bits_address(oa_addr), .auto_out_a_bits_mask(oa_mask), .auto_out_a_bits_data(oa_data),
      .auto_out_a_bits_corrupt(oa_corrupt),
      .auto_out_d_ready(od_ready), .auto_out_d_valid(rsp_v), .auto_out_d_bits_opcode(rsp_op),
      .auto_out_d_bits_size(rsp_size), .auto_out_d_bits_source(rsp_src), .auto_out_d_bits_data(rsp_data),
      .stat_reads(stat_reads), .stat_writes(stat_writes), .stat_errors(stat_errors)
   );

   always #5 clock = ~clock;

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw, input logic [7:0] m);
      logic [63:0] r;
      for (int b = 0; b < 8; b++) r[8*b +: 8] = m[b] ? nw[8*b +: 8] : old[8*b +: 8];
      return r;
   endfunction

   // One-response-slot RAM model, reset alongside the front end.
   assign oa_ready = ram_ready & ~rsp_v;
   always @(posedge clock or posedge reset)
      if (reset) rsp_v <= 1'b0;
      else begin
         if (rsp_v & od_ready) rsp_v <= 1'b0;
         if (oa_valid & oa_ready) begin
            rsp_v    <= 1'b1;
            rsp_op   <= (oa_op == 3'd4) ? 3'd1 : 3'd0;
            rsp_size <= oa_size;
            rsp_src  <= oa_src;
            rsp_data <= (oa_op == 3'd4) ? ram[oa_addr[6:3]] : 64'd0;
            if (oa_op != 3'd4) ram[oa_addr[6:3]] <= merge(ram[oa_addr[6:3]], oa_data, oa_mask);
         end
      end

   always @(posedge clock) if (oa_valid) out_a_cnt <= out_a_cnt + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [2:0] op, input logic [32:0] addr, input logic [9:0] src,
                       input logic [63:0] data);
      int n = 0;
      a_valid = 1'b1; a_op = op; a_addr = addr; a_src = src; a_data = data; a_mask = 8'hFF;
      #1;
      while (!a_ready && n < 30) begin @(posedge clock); #1; n++; end
      if (n == 30) check("a_ready_timeout", a_ready, 1);
      @(posedge clock); #1;
      a_valid = 1'b0;
   endtask

   task automatic recv(input string tag, input logic [2:0] op, input logic den, input logic [9:0] src,
                       input logic [63:0] data);
      int n = 0;
      while (!d_valid && n < 30) begin @(posedge clock); #1; n++; end
      check({tag, "_valid"}, d_valid, 1);
      check({tag, "_op"}, d_op, op);
      check({tag, "_denied"}, d_denied, den);
      check({tag, "_src"}, d_src, src);
      check({tag, "_data"}, d_data, data);
      d_ready = 1'b1;
      @(posedge clock); #1;
      d_ready = 1'b0;
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      #1;
   endtask

   initial begin
      int snap;
      #1;
      check("rst_a_ready", a_ready, 1);
      check("rst_out_a_valid", oa_valid, 0);
      check("rst_d_valid", d_valid, 0);
      check("rst_denied", d_denied, 0);
      check("rst_stat_errors", stat_errors, 0);
      pulse_reset();
      // PutFull then Get through the RAM
      send(3'd0, 33'h080000010, 10'd1, 64'h1122334455667788);
      recv("put", 3'd0, 1'b0, 10'd1, 64'd0);
      send(3'd4, 33'h080000010, 10'd2, 64'd0);
      recv("get", 3'd1, 1'b0, 10'd2, 64'h1122334455667788);
      // Out-of-range Get answered locally
      snap = out_a_cnt;
      send(3'd4, 33'h000001000, 10'h155, 64'd0);
      recv("oob_get", 3'd1, 1'b1, 10'h155, 64'd0);
      check("oob_no_out_a", out_a_cnt, snap);
      // Legal Get then out-of-range Put, D held off for 5 cycles
      send(3'd4, 33'h080000010, 10'd3, 64'd0);
      send(3'd0, 33'h100000000, 10'd4, 64'hDEAD);
      repeat (5) @(posedge clock);
      #1;
      check("order_first_denied", d_denied, 0);
      recv("order_get", 3'd1, 1'b0, 10'd3, 64'h1122334455667788);
      recv("order_put", 3'd0, 1'b1, 10'd4, 64'd0);
      // Window boundaries
      send(3'd4, 33'h07FFFFFFF, 10'd5, 64'd0);
      recv("below_base", 3'd1, 1'b1, 10'd5, 64'd0);
      send(3'd0, 33'h0FFFFFFF8, 10'd6, 64'h55);
      recv("top_put", 3'd0, 1'b0, 10'd6, 64'd0);
      // FIFO full with the RAM stalled
      ram_ready = 1'b0;
      a_valid = 1'b1; a_op = 3'd0; a_addr = 33'h080000020; a_src = 10'd10;
      @(posedge clock); #1 a_src = 10'd11;
      @(posedge clock); #1 a_src = 10'd12;
      check("full_a_ready", a_ready, 0);
      check("full_head_src", oa_src, 10);
      repeat (3) @(posedge clock);
      #1;
      check("full_held", a_ready, 0);
      ram_ready = 1'b1;
      @(posedge clock); #1;
      check("full_freed", a_ready, 1);
      @(posedge clock); #1 a_valid = 1'b0;
      recv("fifo0", 3'd0, 1'b0, 10'd10, 64'd0);
      recv("fifo1", 3'd0, 1'b0, 10'd11, 64'd0);
      recv("fifo2", 3'd0, 1'b0, 10'd12, 64'd0);
      check("stat_reads", stat_reads, STATS ? 64'd2 : 64'd0);
      check("stat_writes", stat_writes, STATS ? 64'd5 : 64'd0);
      check("stat_errors", stat_errors, STATS ? 64'd3 : 64'd0);
      // Unsupported opcode inside the window
      pulse_reset();
      send(3'd3, 33'h080000040, 10'd7, 64'd0);
      recv("arith", 3'd1, 1'b1, 10'd7, 64'd0);
      check("arith_stat_errors", stat_errors, STATS ? 64'd1 : 64'd0);
      // Async reset while a denied response waits
      send(3'd4, 33'h000000000, 10'h2A, 64'd0);
      send(3'd4, 33'h080000010, 10'h2B, 64'd0);
      @(posedge clock); #1;
      check("pend_denied", d_denied, 1);
      check("pend_blocks_legal", oa_valid, 0);
      #2 reset = 1'b1;
      #1;
      check("async_d_valid", d_valid, 0);
      check("async_denied", d_denied, 0);
      check("async_a_ready", a_ready, 1);
      @(posedge clock); #1 reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("post_out_a_valid", oa_valid, 0);
      check("post_d_valid", d_valid, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/tl_ram_front_end.md
Name: tl_ram_front_end

Overview:
- Upstream companion of the 64-bit TileLink RAM slave. Sits between the crossbar edge and the RAM's A/D ports.
- Buffers A-channel requests in a small FIFO and range-checks each request's address.
- Forwards legal requests to the RAM. Answers out-of-range or unsupported-opcode requests locally with a denied response.
- Merges RAM responses and local error responses onto one D channel in strict request order.

Parameters:
- DEPTH, 2, A-request FIFO entries (power of two, >=2)
- BASE_ADDR, 33'h080000000, first byte address served by the RAM
- SIZE_BYTES, 33'h080000000, span of the RAM window in bytes

Ports:
- clock  in  1  block clock
- reset  in  1  asynchronous active-high reset
- auto_in_a_ready  out  1  FIFO not full
- auto_in_a_valid  in  1  upstream A valid
- auto_in_a_bits_opcode  in  3  TL opcode
- auto_in_a_bits_param  in  3  TL param
- auto_in_a_bits_size  in  2  log2 bytes
- auto_in_a_bits_source  in  10  source ID
- auto_in_a_bits_address  in  33  byte address
- auto_in_a_bits_mask  in  8  byte mask
- auto_in_a_bits_data  in  64  write data
- auto_in_a_bits_corrupt  in  1  corrupt flag
- auto_in_d_ready  in  1  upstream D ready
- auto_in_d_valid  out  1  D valid
- auto_in_d_bits_opcode  out  3  0 = AccessAck, 1 = AccessAckData
- auto_in_d_bits_size  out  2  echoed size
- auto_in_d_bits_source  out  10  echoed source
- auto_in_d_bits_denied  out  1  local error response
- auto_in_d_bits_data  out  64  read data
- auto_out_a_*  out/in  same widths as auto_in_a_* (ready is an input)  to RAM A port
- auto_out_d_ready  out  1  to RAM
- auto_out_d_valid, auto_out_d_bits_opcode/size/source/data  in  1/3/2/10/64  from RAM
- stat_reads, stat_writes, stat_errors  out  32 each  counters (see Optional Feature)

Behaviour:
- Reset (async, active-high) clears FIFO, outstanding counter, error register and stats.
- Output values during reset:
  - auto_in_a_ready = 1.
  - auto_out_a_valid = 0.
  - auto_in_d_valid = auto_out_d_valid (pass-through).
  - auto_in_d_bits_denied = 0.
- Reset mid-operation drops queued requests and any pending error response; the RAM is reset alongside.
- FIFO:
  - auto_in_a_ready = ~full.
  - No bypass; minimum latency from in_a fire to out_a_valid is 1 cycle.
  - Enqueue and dequeue in the same cycle are allowed when not full.
  - Pointers wrap modulo DEPTH.
- Head classification:
  - legal = opcode in {0,1,4} and BASE_ADDR <= address < BASE_ADDR+SIZE_BYTES (33-bit compare, no overflow).
- Dispatch of a legal head:
  - auto_out_a_valid = head_valid & legal & ~err_valid.
  - All fields are passed through unchanged.
  - The head dequeues on out_a fire.
- Outstanding counter (2 bits):
  - +1 on out_a fire, -1 on out_d fire; simultaneous increment and decrement nets to no change.
- Error path for an illegal head:
  - Waits until outstanding == 0 and err_valid == 0.
  - Then loads the error register in one cycle and dequeues the head. The register holds size and source, opcode = 1 if the request opcode is in {2,3,4}, else 0.
  - err_valid stays set until auto_in_d_ready.
- D merge:
  - auto_in_d_valid = auto_out_d_valid | err_valid; the two are exclusive by construction.
  - auto_out_d_ready = auto_in_d_ready & ~err_valid.
  - Error response: denied = 1, data = 0.
  - RAM response: denied = 0, fields passed through.
- Ordering: responses always return in request-acceptance order. A legal request queued behind an illegal one is not dispatched until the error response fires.

Optional Feature:
- Macro: TL_RAM_FE_STATS_EN.
- When defined:
  - stat_reads increments on each out_a fire with opcode 4.
  - stat_writes increments on each out_a fire with opcode 0 or 1.
  - stat_errors increments on each error-register load.
  - All three are 32-bit wrapping counters, cleared by reset.
- When undefined: counters are not built and the three outputs are tied to 0.

Test Plan:
- PutFull, mask 0xFF, to 0x080000010 with data 0x1122334455667788, then Get same address -> D opcode 0 then opcode 1, data 0x1122334455667788, denied 0, sources echoed.
- Get to 0x000001000, source 0x155 -> D opcode 1, denied 1, data 0, source 0x155; auto_out_a_valid never asserted.
- Legal Get then out-of-range Put, back-to-back, auto_in_d_ready low for 5 cycles -> RAM AccessAckData first, then denied AccessAck; no reordering.
- DEPTH=2, auto_out_a_ready held 0, offer 3 requests -> two accepted, auto_in_a_ready = 0, third held until a dequeue.
- Opcode 3 to in-range address -> denied AccessAckData, opcode 1; with TL_RAM_FE_STATS_EN, stat_errors = 1.
- Assert reset asynchronously while an error response awaits auto_in_d_ready -> auto_in_d_valid and denied drop to 0 without a clock edge; FIFO empty afterwards.
